ode_result_unloader: RTL and testbench
======================================

// Module: ode_result_unloader
// PURPOSE
//  Downstream of the solver RAM. After processing completes, reads each 64-bit result word from RAM.
//  Streams each word to the CPU as two 32-bit beats over CPU_Bus, low half first.
//  Every beat uses a valid/ack handshake. Reuses the chip's 13-bit RAM address / 64-bit data geometry.
// PARAMETERS
//  RAM_ADDRESS_WIDTH  13  RAM address width; address counter wraps modulo 2**RAM_ADDRESS_WIDTH
//  DATA_WIDTH         64  RAM word width; must equal 2*BUS_WIDTH
//  BUS_WIDTH          32  CPU bus width
// PORTS
//  CLK            in   1     clock, rising edge
//  RST            in   1     asynchronous, active-high reset
//  Start          in   1     one-cycle pulse; begin unloading (tie to Done_Processing edge)
//  Base_Address   in   RAM_ADDRESS_WIDTH    first RAM address, sampled at Start
//  Word_Count     in   RAM_ADDRESS_WIDTH+1  number of 64-bit words, sampled at Start
//  RAM_RD_Address out  RAM_ADDRESS_WIDTH    RAM read address (registered)
//  RAM_RD_Data    in   DATA_WIDTH           RAM read data, valid 1 cycle after address
//  CPU_Ack        in   1     CPU accepted current beat
//  CPU_Bus_Out    out  BUS_WIDTH  beat data; chip top drives inout CPU_Bus when CPU_Bus_OE=1
//  CPU_Bus_OE     out  1     bus output enable
//  Data_Valid     out  1     beat present on bus (interrupt-style strobe to CPU)
//  Busy           out  1     unload in progress
//  Done_Unloading out  1     one-cycle pulse when last beat is acked or count was zero
// BEHAVIOUR
//  Reset values: RAM_RD_Address=0, CPU_Bus_Out=0, CPU_Bus_OE=0, Data_Valid=0, Busy=0, Done_Unloading=0.
//  Reset forces state IDLE. All internal registers clear.
//  FSM states: IDLE, FETCH, WAIT, SEND_LO, SEND_HI, FINISH.
//  IDLE:
//   - On Start: latch Base_Address into addr and Word_Count into remaining. Busy=1.
//   - remaining==0 -> FINISH; else -> FETCH.
//  FETCH: drive RAM_RD_Address=addr -> WAIT.
//  WAIT: capture RAM_RD_Data into 64-bit hold register -> SEND_LO.
//  SEND_LO:
//   - Drive CPU_Bus_Out=hold[31:0], OE=1, Data_Valid=1.
//   - On CPU_Ack: Data_Valid=0 for one cycle, then -> SEND_HI.
//  SEND_HI:
//   - Drive hold[63:32] with the same handshake.
//   - On ack: addr=addr+1 (wraps), remaining=remaining-1.
//   - remaining was 1 -> FINISH; else -> FETCH.
//  FINISH: Done_Unloading=1 for exactly one cycle; Busy=0, OE=0 -> IDLE.
//  Handshake rules:
//   - Data_Valid and bus data stay stable until CPU_Ack is sampled high.
//   - CPU_Ack is ignored when Data_Valid=0.
//   - Data_Valid drops for at least one cycle between beats, so a held-high Ack cannot double-accept.
//  Latency: Start -> first Data_Valid is 3 cycles (FETCH, WAIT, SEND_LO entry). Each word needs >=2 acks.
//  Start while Busy=1: ignored; latched base/count unchanged.
//  Start and CPU_Ack in the same cycle while IDLE: Ack ignored.
//  Address wrap: base=2**AW-1 with count 2 reads addresses 8191, then 0.
//  Reset mid-transfer: OE drops asynchronously; no Done pulse; next Start restarts cleanly.
//  CPU_Bus_OE=1 only in SEND_LO/SEND_HI, so there is no bus contention with load traffic.
// STRUCTURE
//  Shared package: state encoding (localparam codes), BUS_WIDTH, RAM geometry constants.
//  No sub-module needed; one FSM plus address/count/hold registers.
//  Chip top owns the tri-state: CPU_Bus = CPU_Bus_OE ? CPU_Bus_Out : 'z.
//  RAM RD2 port is shared with the IO block via a top-level mux selected by Busy.
// TESTING
//  1. Base=0, Count=1, RAM[0]=64'h1122334455667788, ack each beat after 2 cycles:
//     -> beats 32'h55667788 then 32'h11223344; Done pulses once; Busy falls.
//  2. Count=0 Start -> no Data_Valid, no OE; Done_Unloading exactly 2 cycles after Start.
//  3. Base=8191, Count=2 -> RAM_RD_Address sequence 8191, 0; four beats in order.
//  4. CPU_Ack held high continuously, Count=3 -> exactly 6 beats accepted; Valid gaps seen; no skipped/duplicated data.
//  5. Second Start pulsed during SEND_HI of a Count=2 transfer -> ignored; only 4 beats; one Done.
//  6. RST asserted in SEND_LO -> OE, Valid, Busy 0 immediately.
//     Fresh Start (Base=5, Count=1) -> correct word from RAM[5].

Source files
------------

// File: rtl/ode_result_unloader_pkg.sv
// Shared constants and FSM encoding for the solver-result unloader.
// RAM geometry matches the chip's 13-bit address / 64-bit data result store.
package ode_result_unloader_pkg;

    localparam int unsigned RamAddrWidth = 13;
    localparam int unsigned RamDataWidth = 64;
    localparam int unsigned CpuBusWidth  = 32;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StWait   = 3'd2,
        StSendLo = 3'd3,
        StSendHi = 3'd4,
        StFinish = 3'd5
    } unload_state_e;

endpackage

// File: rtl/ode_result_unloader.sv
// Reads 64-bit result words from the solver RAM and streams each to the CPU as two
// 32-bit beats (low half first), every beat under a valid/ack handshake.
module ode_result_unloader
    import ode_result_unloader_pkg::*;
#(
    parameter int unsigned RAM_ADDRESS_WIDTH = RamAddrWidth,
    parameter int unsigned DATA_WIDTH        = RamDataWidth,
    parameter int unsigned BUS_WIDTH         = CpuBusWidth
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         Start,
    input  logic [RAM_ADDRESS_WIDTH-1:0] Base_Address,
    input  logic [RAM_ADDRESS_WIDTH:0]   Word_Count,
    output logic [RAM_ADDRESS_WIDTH-1:0] RAM_RD_Address,
    input  logic [DATA_WIDTH-1:0]        RAM_RD_Data,
    input  logic                         CPU_Ack,
    output logic [BUS_WIDTH-1:0]         CPU_Bus_Out,
    output logic                         CPU_Bus_OE,
    output logic                         Data_Valid,
    output logic                         Busy,
    output logic                         Done_Unloading
);

    localparam logic [RAM_ADDRESS_WIDTH-1:0] AddrOne  = 1;
    localparam logic [RAM_ADDRESS_WIDTH:0]   CountOne = 1;

    unload_state_e                state_q, state_d;
    logic [RAM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [RAM_ADDRESS_WIDTH:0]   remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0]        hold_q, hold_d;
    // Set for the single cycle after a low-beat ack, forcing Data_Valid low.
    logic                         ackd_q, ackd_d;
    logic                         done_q, done_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = (Word_Count == '0) ? StFinish : StFetch;
                end
            end
            StFetch:  state_d = StWait;
            StWait:   state_d = StSendLo;
            StSendLo: begin
                if (ackd_q) begin
                    state_d = StSendHi;
                end
            end
            StSendHi: begin
                if (CPU_Ack) begin
                    state_d = (remaining_q == CountOne) ? StFinish : StFetch;
                end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        remaining_d = remaining_q;
        hold_d      = hold_q;
        ackd_d      = 1'b0;
        done_d      = (state_q == StFinish);
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    addr_d      = Base_Address;
                    remaining_d = Word_Count;
                end
            end
            StWait:   hold_d = RAM_RD_Data;
            StSendLo: ackd_d = !ackd_q && CPU_Ack;
            StSendHi: begin
                if (CPU_Ack) begin
                    addr_d      = addr_q + AddrOne;
                    remaining_d = remaining_q - CountOne;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q      <= '0;
            remaining_q <= '0;
            hold_q      <= '0;
            ackd_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            hold_q      <= hold_d;
            ackd_q      <= ackd_d;
            done_q      <= done_d;
        end
    end

    // Outputs decode straight from state so a reset drops OE/Valid/Busy without a clock.
    always_comb begin
        CPU_Bus_Out = '0;
        CPU_Bus_OE  = 1'b0;
        Data_Valid  = 1'b0;
        Busy        = 1'b0;
        unique case (state_q)
            StFetch, StWait: Busy = 1'b1;
            StSendLo: begin
                CPU_Bus_Out = hold_q[BUS_WIDTH-1:0];
                CPU_Bus_OE  = 1'b1;
                Data_Valid  = !ackd_q;
                Busy        = 1'b1;
            end
            StSendHi: begin
                CPU_Bus_Out = hold_q[DATA_WIDTH-1:BUS_WIDTH];
                CPU_Bus_OE  = 1'b1;
                Data_Valid  = 1'b1;
                Busy        = 1'b1;
            end
            default: ;
        endcase
    end

    assign RAM_RD_Address = addr_q;
    assign Done_Unloading = done_q;

endmodule

// File: tb/tb_ode_result_unloader.sv
// Self-checking bench for ode_result_unloader: random RAM contents and ack timing,
// beats compared against a word-list model of the expected transfer.
module tb_ode_result_unloader;

    localparam int AW    = 13;
    localparam int DW    = 64;
    localparam int BW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          Start = 1'b0;
    logic [AW-1:0] Base_Address = '0;
    logic [AW:0]   Word_Count = '0;
    logic [AW-1:0] RAM_RD_Address;
    logic [DW-1:0] RAM_RD_Data;
    logic          CPU_Ack = 1'b0;
    logic [BW-1:0] CPU_Bus_Out;
    logic          CPU_Bus_OE;
    logic          Data_Valid;
    logic          Busy;
    logic          Done_Unloading;

    ode_result_unloader dut (
        .CLK            (CLK),
        .RST            (RST),
        .Start          (Start),
        .Base_Address   (Base_Address),
        .Word_Count     (Word_Count),
        .RAM_RD_Address (RAM_RD_Address),
        .RAM_RD_Data    (RAM_RD_Data),
        .CPU_Ack        (CPU_Ack),
        .CPU_Bus_Out    (CPU_Bus_Out),
        .CPU_Bus_OE     (CPU_Bus_OE),
        .Data_Valid     (Data_Valid),
        .Busy           (Busy),
        .Done_Unloading (Done_Unloading)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read RAM model: data one cycle after address.
    logic [DW-1:0] mem [0:DEPTH-1];
    always @(posedge CLK) RAM_RD_Data <= mem[RAM_RD_Address];

    int n_cmp = 0;
    int n_fail = 0;

    // Observed traffic.
    logic [BW-1:0] acc_q[$];
    logic [AW-1:0] addr_log[$];
    int done_cnt, gap_err, stab_err, oe_err, valid_seen, oe_seen;
    logic prev_valid = 1'b0, prev_ack = 1'b0, prev_fetch = 1'b0;
    logic [BW-1:0] prev_data = '0;

    // Expected traffic.
    logic [BW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr[$];

    always @(negedge CLK) begin
        if (RST) begin
            prev_valid = 1'b0;
            prev_fetch = 1'b0;
        end else begin
            if (Done_Unloading) done_cnt++;
            if (Data_Valid) valid_seen++;
            if (CPU_Bus_OE) oe_seen++;
            if (Data_Valid && !CPU_Bus_OE) oe_err++;
            if (prev_valid && prev_ack && Data_Valid) gap_err++;
            if (prev_valid && !prev_ack && (!Data_Valid || CPU_Bus_Out !== prev_data)) stab_err++;
            if (Data_Valid && CPU_Ack) acc_q.push_back(CPU_Bus_Out);
            if (Busy && !CPU_Bus_OE && !prev_fetch) addr_log.push_back(RAM_RD_Address);
            prev_fetch = Busy && !CPU_Bus_OE;
            prev_valid = Data_Valid;
            prev_ack   = CPU_Ack;
            prev_data  = CPU_Bus_Out;
        end
    end

    // CPU model: 0 = ack after a random delay, 1 = ack held high, 2 = never ack.
    int ack_mode = 0;
    int ack_dly_min = 0;
    int ack_dly_max = 3;
    initial begin
        int cnt = 0;
        int dly = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (ack_mode == 1) CPU_Ack = 1'b1;
            else if (ack_mode == 2) CPU_Ack = 1'b0;
            else if (Data_Valid) begin
                cnt++;
                CPU_Ack = (cnt > dly);
            end else begin
                CPU_Ack = 1'b0;
                cnt = 0;
                dly = $urandom_range(ack_dly_max, ack_dly_min);
            end
        end
    end

    function automatic void build_exp(input int base, input int cnt);
        exp_q.delete();
        exp_addr.delete();
        for (int i = 0; i < cnt; i++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] w;
            a = AW'((base + i) % DEPTH);
            w = mem[a];
            exp_addr.push_back(a);
            exp_q.push_back(w[BW-1:0]);
            exp_q.push_back(w[DW-1:BW]);
        end
    endfunction

    // Number of beats that differ from the model, counting missing or extra beats.
    function automatic int beat_diffs();
        int n = (acc_q.size() > exp_q.size()) ? acc_q.size() - exp_q.size()
                                              : exp_q.size() - acc_q.size();
        for (int i = 0; i < acc_q.size() && i < exp_q.size(); i++)
            if (acc_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    function automatic int addr_diffs();
        int n = (addr_log.size() > exp_addr.size()) ? addr_log.size() - exp_addr.size()
                                                    : exp_addr.size() - addr_log.size();
        for (int i = 0; i < addr_log.size() && i < exp_addr.size(); i++)
            if (addr_log[i] !== exp_addr[i]) n++;
        return n;
    endfunction

    task automatic clear_mon();
        acc_q.delete();
        addr_log.delete();
        done_cnt = 0; gap_err = 0; stab_err = 0; oe_err = 0; valid_seen = 0; oe_seen = 0;
    endtask

    task automatic pulse_start(input int base, input int cnt);
        @(posedge CLK);
        #2;
        Start = 1'b1;
        Base_Address = AW'(base);
        Word_Count = (AW + 1)'(cnt);
        @(posedge CLK);
        #2;
        Start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge CLK);
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_reset();
        @(negedge CLK);
        n_cmp++;
        if ({RAM_RD_Address, CPU_Bus_Out, CPU_Bus_OE, Data_Valid, Busy, Done_Unloading} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: addr=%0d bus=%h oe=%b v=%b busy=%b done=%b, want all 0",
                     RAM_RD_Address, CPU_Bus_Out, CPU_Bus_OE, Data_Valid, Busy, Done_Unloading);
        end
        @(posedge CLK);
        #2;
        RST = 1'b0;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if ({CPU_Bus_OE, Data_Valid, Busy, Done_Unloading} !== 4'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: oe/v/busy/done=%b%b%b%b want 0000",
                     CPU_Bus_OE, Data_Valid, Busy, Done_Unloading);
        end
    endtask

    task automatic test_single();
        logic [2:0] lat;
        mem[0] = 64'h1122334455667788;
        ack_mode = 0; ack_dly_min = 2; ack_dly_max = 2;
        build_exp(0, 1);
        clear_mon();
        pulse_start(0, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            lat[2-i] = Data_Valid;
        end
        n_cmp++;
        if (lat !== 3'b001) begin
            n_fail++;
            $display("FAIL single_latency: valid over 3 cycles=%b want 001", lat);
        end
        wait_done(200);
        n_cmp++;
        if (beat_diffs() !== 0) begin
            n_fail++;
            $display("FAIL single_beats: got %0d beats (%0d wrong) want 2 [55667788,11223344]",
                     acc_q.size(), beat_diffs());
        end
        n_cmp++;
        if (done_cnt !== 1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: done pulses=%0d busy=%b want 1 and 0", done_cnt, Busy);
        end
        n_cmp++;
        if (gap_err + stab_err + oe_err !== 0) begin
            n_fail++;
            $display("FAIL single_handshake: gap=%0d stab=%0d oe=%0d want 0", gap_err, stab_err, oe_err);
        end
    endtask

    task automatic test_zero_count();
        logic [2:0] d;
        clear_mon();
        pulse_start($urandom_range(DEPTH - 1, 0), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            d[2-i] = Done_Unloading;
        end
        repeat (5) @(negedge CLK);
        n_cmp++;
        if (d !== 3'b010) begin
            n_fail++;
            $display("FAIL zero_done_timing: done over 3 cycles=%b want 010", d);
        end
        n_cmp++;
        if (valid_seen !== 0 || oe_seen !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL zero_no_beats: valid=%0d oe=%0d done=%0d want 0 0 1",
                     valid_seen, oe_seen, done_cnt);
        end
    endtask

    task automatic test_wrap();
        ack_mode = 0; ack_dly_min = 0; ack_dly_max = 3;
        build_exp(DEPTH - 1, 2);
        clear_mon();
        pulse_start(DEPTH - 1, 2);
        wait_done(400);
        n_cmp++;
        if (addr_diffs() !== 0) begin
            n_fail++;
            $display("FAIL wrap_addresses: got %0d reads (%0d wrong) want 8191 then 0",
                     addr_log.size(), addr_diffs());
        end
        n_cmp++;
        if (beat_diffs() !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL wrap_beats: got %0d beats (%0d wrong) done=%0d want 4 and 1",
                     acc_q.size(), beat_diffs(), done_cnt);
        end
    endtask

    task automatic test_ack_held();
        int base = $urandom_range(DEPTH - 1, 0);
        ack_mode = 1;
        build_exp(base, 3);
        clear_mon();
        repeat (2) @(posedge CLK);
        pulse_start(base, 3);
        wait_done(400);
        ack_mode = 0;
        n_cmp++;
        if (beat_diffs() !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL held_beats: got %0d beats (%0d wrong) done=%0d want 6 and 1",
                     acc_q.size(), beat_diffs(), done_cnt);
        end
        n_cmp++;
        if (gap_err + stab_err !== 0) begin
            n_fail++;
            $display("FAIL held_gaps: gap=%0d stab=%0d want 0", gap_err, stab_err);
        end
    endtask

    task automatic test_busy_start();
        int base = $urandom_range(DEPTH - 1, 0);
        bit found = 0;
        ack_mode = 0; ack_dly_min = 2; ack_dly_max = 3;
        build_exp(base, 2);
        clear_mon();
        pulse_start(base, 2);
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge CLK);
            #1;
            found = (acc_q.size() == 1) && Data_Valid;
        end
        pulse_start((base + 100) % DEPTH, 3);
        wait_done(400);
        repeat (20) @(negedge CLK);
        n_cmp++;
        if (!found || beat_diffs() !== 0) begin
            n_fail++;
            $display("FAIL busy_start_beats: reached_hi=%0d got %0d beats (%0d wrong) want 4",
                     found, acc_q.size(), beat_diffs());
        end
        n_cmp++;
        if (done_cnt !== 1 || Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_start_done: done=%0d busy=%b want 1 and 0", done_cnt, Busy);
        end
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        ack_mode = 2;
        clear_mon();
        pulse_start($urandom_range(DEPTH - 1, 0), 2);
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge CLK);
            found = Data_Valid;
        end
        #1;
        RST = 1'b1;
        #1;
        n_cmp++;
        if (!found || {CPU_Bus_OE, Data_Valid, Busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_async: reached_lo=%0d oe/v/busy=%b%b%b want 000",
                     found, CPU_Bus_OE, Data_Valid, Busy);
        end
        @(posedge CLK);
        #2;
        RST = 1'b0;
        ack_mode = 0; ack_dly_min = 0; ack_dly_max = 3;
        repeat (5) @(negedge CLK);
        n_cmp++;
        if (done_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_no_done: done pulses=%0d want 0", done_cnt);
        end
        mem[5] = {$urandom, $urandom};
        build_exp(5, 1);
        clear_mon();
        pulse_start(5, 1);
        wait_done(200);
        n_cmp++;
        if (beat_diffs() !== 0 || addr_diffs() !== 0 || done_cnt !== 1) begin
            n_fail++;
            $display("FAIL reset_mid_restart: beats=%0d (%0d wrong) addr_err=%0d done=%0d want 2,0,0,1",
                     acc_q.size(), beat_diffs(), addr_diffs(), done_cnt);
        end
    endtask

    task automatic test_random();
        ack_mode = 0; ack_dly_min = 0; ack_dly_max = 3;
        for (int t = 0; t < 5; t++) begin
            int base = $urandom_range(DEPTH - 1, 0);
            int cnt = $urandom_range(4, 1);
            build_exp(base, cnt);
            clear_mon();
            pulse_start(base, cnt);
            wait_done(600);
            n_cmp++;
            if (beat_diffs() !== 0 || addr_diffs() !== 0 || done_cnt !== 1 ||
                gap_err + stab_err + oe_err !== 0) begin
                n_fail++;
                $display("FAIL random_%0d: base=%0d cnt=%0d beats=%0d (%0d wrong) addr_err=%0d done=%0d hs_err=%0d want %0d,0,0,1,0",
                         t, base, cnt, acc_q.size(), beat_diffs(), addr_diffs(), done_cnt,
                         gap_err + stab_err + oe_err, 2 * cnt);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom};
        test_reset();
        test_single();
        test_zero_count();
        test_wrap();
        test_ack_held();
        test_busy_start();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
